// File: rtl/fb_write_scheduler_pkg.sv
// Shared framebuffer constants and types used by the write scheduler and its
// neighbours (command decoder, framebuffer RAM).
package fb_write_scheduler_pkg;

    localparam int unsigned FB_ADDR_W = 10;   // 5-bit row, 5-bit column
    localparam int unsigned FB_DATA_W = 8;    // colour lives in [2:0]
    localparam int unsigned FB_CELLS  = 1024;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sched_state_t;

    // One framebuffer write as it travels from decoder to RAM.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_write_scheduler_fifo.sv
// Circular-buffer FIFO with flush. A flush discards every stored entry but
// keeps a push arriving in the same cycle, so that push lands after the flush.
// Ports: clk, reset (active-low, sync), push/push_data, pop, flush,
//        pop_data (head, combinational), full, empty,
//        drop_c (push refused this cycle: full with no pop and no flush).
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when a slot frees up in the same cycle.
    assign do_push = push & (~full | pop | flush);
    assign do_pop  = pop & ~empty & ~flush;
    assign drop_c  = push & ~do_push;

    // Storage: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= CNT_W'(do_push);
            end else begin
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-low reset.
// Ports: clk, reset (active-low, sync), en (load), d (next value), q (held value).
module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Single owner of the framebuffer write port. Queues decoder pixel writes and
// runs full-screen clear sweeps; a clear discards older queued writes and any
// write pushed alongside or after the request is issued after the sweep.
// Ports: clk, reset (active-low, sync);
//        dec_valid/dec_we/dec_waddr/dec_wdata from the command decoder;
//        clear_req (one-cycle strobe);
//        fb_we/fb_waddr/fb_wdata registered RAM write port;
//        clear_busy, fifo_full, overflow (sticky dropped-write flag).
module fb_write_scheduler
    import fb_write_scheduler_pkg::*;
#(
    parameter int unsigned        ADDR_W      = FB_ADDR_W,
    parameter int unsigned        DATA_W      = FB_DATA_W,
    parameter int unsigned        FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0]  CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_waddr,
    input  logic [DATA_W-1:0] dec_wdata,
    input  logic              clear_req,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              clear_busy,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int unsigned       ENTRY_W   = ADDR_W + DATA_W;
    // Extra counter bit keeps the end-of-sweep compare free of wrap aliasing.
    localparam logic [ADDR_W:0]   LAST_CELL = {1'b0, {ADDR_W{1'b1}}};

    sched_state_t       state;
    sched_state_t       state_n;
    logic [ADDR_W:0]    cnt;
    logic [ADDR_W:0]    cnt_n;
    logic               busy_n;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_empty;
    logic               fifo_drop;
    logic [ENTRY_W-1:0] fifo_head;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    // Write-enable-low decoder strobes (including its idle 3FF/FF pattern) are ignored.
    assign fifo_push = dec_valid & dec_we;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({dec_waddr, dec_wdata}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop_c    (fifo_drop)
    );

    // Next-state, sweep counter and next write-port values.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n    = CLEAR;
                    cnt_n      = '0;
                    fifo_flush = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_en    = 1'b1;
                    wr_addr  = fifo_head[ENTRY_W-1:DATA_W];
                    wr_data  = fifo_head[DATA_W-1:0];
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt[ADDR_W-1:0];
                wr_data = CLEAR_COLOR;
                if (clear_req) begin
                    // Current cell is still written; the sweep restarts behind it.
                    cnt_n      = '0;
                    fifo_flush = 1'b1;
                end else begin
                    cnt_n = cnt + (ADDR_W + 1)'(1);
                    if (cnt == LAST_CELL) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Busy covers the sweep plus the cycle showing its final write.
        busy_n = (state_n == CLEAR) || (state == CLEAR);
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fb_we      <= 1'b0;
            clear_busy <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            fb_we      <= wr_en;
            clear_busy <= busy_n;
            overflow   <= overflow | fifo_drop;
        end
    end

    // Address/data hold their last value when no write is issued.
    flopenr #(.WIDTH(ADDR_W)) u_waddr_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .d     (wr_addr),
        .q     (fb_waddr)
    );

    flopenr #(.WIDTH(DATA_W)) u_wdata_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .d     (wr_data),
        .q     (fb_wdata)
    );

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed self-checking bench for fb_write_scheduler.
module tb_fb_write_scheduler;
    import fb_write_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic       dec_we;
    logic [9:0] dec_waddr;
    logic [7:0] dec_wdata;
    logic       clear_req;
    logic       fb_we;
    logic [9:0] fb_waddr;
    logic [7:0] fb_wdata;
    logic       clear_busy;
    logic       fifo_full;
    logic       overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned wr_count = 0;
    int unsigned wr_base;
    fb_wr_t      exp_wr;

    fb_write_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_we     (dec_we),
        .dec_waddr  (dec_waddr),
        .dec_wdata  (dec_wdata),
        .clear_req  (clear_req),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
        .clear_busy (clear_busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Count every RAM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_we === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [9:0] a, input logic [7:0] d);
        dec_valid = 1'b1;
        dec_we    = 1'b1;
        dec_waddr = a;
        dec_wdata = d;
    endtask

    task automatic clr_push();
        dec_valid = 1'b0;
        dec_we    = 1'b0;
    endtask

    function automatic fb_wr_t entry(input int i);
        fb_wr_t e;
        e.addr = 10'(32'h040 + i * 3);
        e.data = 8'(i + 1);
        return e;
    endfunction

    // Check one full sweep of clear writes, one per cycle, ending in the cycle after the last.
    task automatic check_sweep(input string tag);
        for (int k = 0; k < FB_CELLS; k++) begin
            check(tag, 32'({clear_busy, fb_we, fb_waddr, fb_wdata}),
                  32'({1'b1, 1'b1, 10'(k), 8'h00}));
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        dec_valid = 1'b0;
        dec_we    = 1'b0;
        dec_waddr = '0;
        dec_wdata = '0;
        clear_req = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_we",    32'(fb_we),      32'd0);
        check("rst_waddr", 32'(fb_waddr),   32'd0);
        check("rst_wdata", 32'(fb_wdata),   32'd0);
        check("rst_busy",  32'(clear_busy), 32'd0);
        check("rst_full",  32'(fifo_full),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        reset = 1'b1;
        tick();

        // Single push: write visible two cycles later for exactly one cycle
        set_push(10'h021, 8'h05);
        tick();
        clr_push();
        check("p1_lat_we", 32'(fb_we), 32'd0);
        tick();
        check("p1_write", 32'({fb_we, fb_waddr, fb_wdata}), 32'({1'b1, 10'h021, 8'h05}));
        check("p1_full",  32'(fifo_full), 32'd0);
        check("p1_ovf",   32'(overflow),  32'd0);
        tick();
        check("p1_hold", 32'({fb_we, fb_waddr, fb_wdata}), 32'({1'b0, 10'h021, 8'h05}));

        // Decoder default pattern with write enable low is ignored
        dec_valid = 1'b1;
        dec_we    = 1'b0;
        dec_waddr = 10'h3FF;
        dec_wdata = 8'hFF;
        tick();
        clr_push();
        tick();
        check("ign_1", 32'({fb_we, fb_waddr, fb_wdata}), 32'({1'b0, 10'h021, 8'h05}));
        tick();
        check("ign_2", 32'(fb_we), 32'd0);

        // Fill FIFO during a clear, then push+pop while full at the first pop
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("a_start", 32'({clear_busy, fb_we}), 32'({1'b1, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            exp_wr = entry(i);
            set_push(exp_wr.addr, exp_wr.data);
            tick();
        end
        clr_push();
        check("a_full", 32'(fifo_full), 32'd1);
        check("a_ovf0", 32'(overflow),  32'd0);
        repeat (1020) tick();
        check("a_last_clr", 32'({clear_busy, fb_we, fb_waddr, fb_wdata}),
              32'({1'b1, 1'b1, 10'h3FF, 8'h00}));
        exp_wr = entry(4);
        set_push(exp_wr.addr, exp_wr.data);
        tick();
        clr_push();
        check("a_full_pp", 32'(fifo_full), 32'd1);
        check("a_ovf_pp",  32'(overflow),  32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_wr = entry(i);
            check("a_drain", 32'({clear_busy, fb_we, fb_waddr, fb_wdata}),
                  32'({1'b0, 1'b1, exp_wr.addr, exp_wr.data}));
            tick();
        end
        check("a_done", 32'({fb_we, fifo_full, clear_busy}), 32'd0);

        // Six pushes into a depth-4 FIFO during a clear: two dropped, overflow sticky
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_wr = entry(i + 8);
            set_push(exp_wr.addr, exp_wr.data);
            tick();
            if (i == 3) begin
                check("b_full4", 32'(fifo_full), 32'd1);
                check("b_ovf4",  32'(overflow),  32'd0);
            end
            if (i == 4) check("b_ovf5", 32'(overflow), 32'd1);
        end
        clr_push();
        repeat (1018) tick();
        check("b_last_clr", 32'({clear_busy, fb_we, fb_waddr}), 32'({1'b1, 1'b1, 10'h3FF}));
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_wr = entry(i + 8);
            check("b_drain", 32'({clear_busy, fb_we, fb_waddr, fb_wdata}),
                  32'({1'b0, 1'b1, exp_wr.addr, exp_wr.data}));
            tick();
        end
        check("b_after", 32'({fb_we, fifo_full}), 32'd0);
        check("b_sticky", 32'(overflow), 32'd1);

        // clear_req with a same-edge push: push written right after the sweep
        clear_req = 1'b1;
        set_push(10'h3E0, 8'h02);
        tick();
        clear_req = 1'b0;
        clr_push();
        check("c_first", 32'({clear_busy, fb_we}), 32'({1'b1, 1'b0}));
        tick();
        check_sweep("c_sweep");
        check("c_push", 32'({clear_busy, fb_we, fb_waddr, fb_wdata}),
              32'({1'b0, 1'b1, 10'h3E0, 8'h02}));
        tick();
        check("c_idle", 32'({clear_busy, fb_we}), 32'd0);

        // Restart at sweep address 500 with two queued writes that must vanish
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wr_base = wr_count;
        set_push(10'h111, 8'h11);
        tick();
        set_push(10'h222, 8'h22);
        tick();
        clr_push();
        repeat (498) tick();
        check("d_at499", 32'({fb_we, fb_waddr}), 32'({1'b1, 10'd499}));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("d_at500", 32'({clear_busy, fb_we, fb_waddr}), 32'({1'b1, 1'b1, 10'd500}));
        tick();
        check_sweep("d_sweep");
        check("d_end", 32'({clear_busy, fb_we}), 32'd0);
        repeat (3) tick();
        check("d_total", 32'(wr_count - wr_base), 32'd1525);

        // Reset during a clear at address 300 aborts the sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (300) tick();
        check("e_at299", 32'({fb_we, fb_waddr}), 32'({1'b1, 10'd299}));
        reset = 1'b0;
        tick();
        check("e_rst", 32'({clear_busy, fb_we, fifo_full, overflow}), 32'd0);
        check("e_rst_addr", 32'(fb_waddr), 32'd0);
        reset   = 1'b1;
        wr_base = wr_count;
        repeat (20) tick();
        check("e_quiet", 32'(wr_count - wr_base), 32'd0);
        check("e_busy",  32'(clear_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
